dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder for the 5-stage pipeline's MEM stage.
- Serves word read/write requests from the pipeline's memread/memwrite/address/write-data signals after a programmable wait-state latency.
- Drives a combinational busy line the pipeline ORs into its stall logic.
- Provides an independent combinational debug read port for the seven-segment display path.

Parameters:
- ADDR_W, 8, word-index width; memory holds 2^ADDR_W 32-bit words.
- LATENCY, 2, wait cycles from request accept to access; legal range 1..255.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- req_read  input  1  read request (pipeline MEM_memread).
- req_write  input  1  write request (pipeline MEM_memwrite).
- addr  input  32  byte address (pipeline MEM_aluout).
- wdata  input  32  write data (pipeline MEM_regout).
- rdata  output  32  read data, registered.
- busy  output  1  stall request to the pipeline.
- done  output  1  one-cycle completion pulse.
- err  output  1  access fault, valid with done.
- dbg_addr  input  ADDR_W  debug word index.
- dbg_data  output  32  combinational memory word at dbg_addr.

Behaviour:
- Reset:
  - Asynchronous, active-high.
  - Forces state=IDLE, counter=0, rdata=0, done=0, err=0, all captured request registers to 0.
  - Memory array contents are not cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If req_write or req_read is sampled high on a clk edge: capture op, addr and wdata; load counter=LATENCY-1; go to WAIT.
  - If both are high, the request is a write.
- WAIT:
  - Counter decrements each cycle.
  - When counter==0, perform the access at word index addr[ADDR_W+1:2]:
    - write: mem[idx] <= wdata;
    - read: rdata <= mem[idx].
  - Then go to RESP.
  - Request inputs are ignored while in WAIT; the captured values are used.
- RESP:
  - done=1 for exactly this cycle. err is valid in this cycle.
  - Go to IDLE next cycle unconditionally.
  - A request held high during RESP is not accepted.
  - The pipeline advances in RESP, so the next request is sampled in IDLE.
- busy (combinational):
  - busy = (IDLE and (req_read or req_write)) or WAIT.
  - busy=0 in RESP.
  - This guarantees the MEM-stage instruction is held until completion.
- Latency: request asserted in cycle N is accepted at the end of N; done is high in cycle N+LATENCY+1.
- rdata holds its last read value until the next read completes; writes do not change it.
- Address bits addr[1:0] and addr[31:ADDR_W+2] are ignored unless the optional feature is enabled.
- Reset mid-operation: a pending write in WAIT is discarded; the memory word is unchanged.
- dbg_data = mem[dbg_addr], combinational, independent of FSM state. A write becomes visible on dbg_data the cycle after it commits.

Optional Feature:
- Macro: DMEM_ALIGN_CHECK_EN.
- Defined:
  - At access time, if addr[1:0]!=0 or addr[31:ADDR_W+2]!=0, the access is faulted.
  - A faulted write is suppressed.
  - A faulted read sets rdata=0.
  - err=1 during RESP; err=0 in all other cycles and for clean accesses.
  - FSM timing is identical.
- Undefined:
  - err is tied to 0.
  - Low and high address bits are ignored; the address wraps modulo 2^ADDR_W words.

Test Plan:
- LATENCY=2, rst then write addr=0x10, wdata=0xDEADBEEF for one request -> busy high 3 cycles (IDLE-accept plus 2 WAIT), done in cycle 4, dbg_addr=4 shows 0xDEADBEEF afterwards.
- Read addr=0x10 after the previous write -> done 3 cycles after accept edge; rdata=0xDEADBEEF in the done cycle and held afterwards; rdata unchanged by a following write to addr 0x14.
- Back-to-back: request held high through RESP -> second access not started until IDLE; exactly one done per accepted request; busy low exactly in each RESP cycle.
- req_read and req_write both high, addr=0x20, wdata=0x12345678 -> treated as write; dbg word 8 becomes 0x12345678; rdata unchanged.
- rst asserted mid-WAIT of a write of 0xAAAA5555 to word 3 previously holding 0x1 -> immediate IDLE, busy=0, done=0, rdata=0; word 3 still 0x1.
- With DMEM_ALIGN_CHECK_EN, write addr=0x12 -> err=1 with done; target word unchanged. Without the macro, the same write lands in word 4 and err stays 0.

Source files
------------

// File: rtl/dmem_responder.sv
// MEM-stage data memory responder: wait-state FSM, combinational stall line and debug read port.
// Optional alignment/range fault detection is built when DMEM_ALIGN_CHECK_EN is defined.
module dmem_responder #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_read,
  input  logic              req_write,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [31:0]       dbg_data
);

  localparam int          DEPTH  = 1 << ADDR_W;
  localparam logic [7:0]  CNT_LD = 8'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            r_state;
  logic [7:0]        r_cnt;
  logic              r_wr;
  logic              r_bad;
  logic [ADDR_W-1:0] r_idx;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;
  logic              r_done;
  logic              r_err;
  logic [31:0]       r_mem [0:DEPTH-1];

  logic [ADDR_W-1:0] w_idx;
  logic              w_bad;
  logic              w_req;
  logic              w_access;
  logic              w_mem_we;

  assign w_idx = addr[ADDR_W+1:2];
  assign w_req = req_read | req_write;

`ifdef DMEM_ALIGN_CHECK_EN
  assign w_bad = (addr[1:0] != 2'b00) || (addr[31:ADDR_W+2] != '0);
`else
  // Out-of-range bits are dropped, so the word index wraps.
  logic w_unused_addr;
  assign w_unused_addr = ^{addr[1:0], addr[31:ADDR_W+2]};
  assign w_bad = 1'b0;
`endif

  assign w_access = (r_state == WAIT) && (r_cnt == 8'd0);
  assign w_mem_we = w_access && r_wr && !r_bad;

  // Array has no reset; only the FSM state gates writes, so a reset in WAIT drops the write.
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[r_idx] <= r_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 8'd0;
      r_wr    <= 1'b0;
      r_bad   <= 1'b0;
      r_idx   <= '0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_wr    <= req_write;
            r_bad   <= w_bad;
            r_idx   <= w_idx;
            r_wdata <= wdata;
            r_cnt   <= CNT_LD;
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (r_cnt == 8'd0) begin
            if (!r_wr) r_rdata <= r_bad ? 32'd0 : r_mem[r_idx];
            r_done  <= 1'b1;
            r_err   <= r_bad;
            r_state <= RESP;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        RESP: begin
          r_done  <= 1'b0;
          r_err   <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy     = ((r_state == IDLE) && w_req) || (r_state == WAIT);
  assign done     = r_done;
  assign err      = r_err;
  assign rdata    = r_rdata;
  assign dbg_data = r_mem[dbg_addr];

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (ADDR_W=8, LATENCY=2); expectations are hand-derived.
module tb_dmem_responder;

`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALN = 1'b1;
`else
  localparam bit ALN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_read, req_write;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        busy, done, err;
  logic [7:0]  dbg_addr;
  logic [31:0] dbg_data;

  int n_chk  = 0;
  int n_fail = 0;
  int n_done = 0;

  dmem_responder #(.ADDR_W(8), .LATENCY(2)) dut (
    .clk(clk), .rst(rst), .req_read(req_read), .req_write(req_write),
    .addr(addr), .wdata(wdata), .rdata(rdata), .busy(busy), .done(done),
    .err(err), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One request: busy for accept + 2 WAIT cycles, done in the 4th cycle, then idle.
  task automatic op(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                    input logic e_err, input logic chk_rd, input logic [31:0] e_rd);
    req_read = rd; req_write = wr; addr = a; wdata = d;
    #1;
    chk("busy_accept", 32'(busy), 32'd1);
    chk("done_accept", 32'(done), 32'd0);
    tick();
    req_read = 1'b0; req_write = 1'b0; addr = 32'hFFFF_FFFF; wdata = 32'h0BAD_0BAD;
    #1;
    chk("busy_wait1", 32'(busy), 32'd1);
    chk("done_wait1", 32'(done), 32'd0);
    tick(); #1;
    chk("busy_wait2", 32'(busy), 32'd1);
    chk("done_wait2", 32'(done), 32'd0);
    tick(); #1;
    chk("done_resp", 32'(done), 32'd1);
    chk("busy_resp", 32'(busy), 32'd0);
    chk("err_resp", 32'(err), 32'(e_err));
    if (chk_rd) chk("rdata_resp", rdata, e_rd);
    tick(); #1;
    chk("done_after", 32'(done), 32'd0);
    chk("err_after", 32'(err), 32'd0);
  endtask

  initial begin
    rst = 1'b1; req_read = 1'b0; req_write = 1'b0;
    addr = 32'd0; wdata = 32'd0; dbg_addr = 8'd0;
    tick();
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick();

    // Write then debug-port visibility.
    op(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 32'd0);
    dbg_addr = 8'd4; #1;
    chk("dbg_w4", dbg_data, 32'hDEADBEEF);
    chk("rdata_after_wr", rdata, 32'd0);

    // Read back, rdata held, unaffected by a later write.
    op(1'b1, 1'b0, 32'h10, 32'd0, 1'b0, 1'b1, 32'hDEADBEEF);
    tick();
    chk("rdata_hold", rdata, 32'hDEADBEEF);
    op(1'b0, 1'b1, 32'h14, 32'h0000_0055, 1'b0, 1'b0, 32'd0);
    chk("rdata_after_w5", rdata, 32'hDEADBEEF);
    dbg_addr = 8'd5; #1;
    chk("dbg_w5", dbg_data, 32'h0000_0055);

    // Back-to-back: read held high through RESP, second accept only from IDLE.
    req_read = 1'b1; addr = 32'h14;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("b2b_busy%0d", i), 32'(busy), (i == 3 || i == 7) ? 32'd0 : 32'd1);
      chk($sformatf("b2b_done%0d", i), 32'(done), (i == 3 || i == 7) ? 32'd1 : 32'd0);
      if (done) n_done++;
      if (i == 7) req_read = 1'b0;
      tick();
    end
    #1;
    chk("b2b_ndone", 32'(n_done), 32'd2);
    chk("b2b_idle_done", 32'(done), 32'd0);
    chk("b2b_idle_busy", 32'(busy), 32'd0);
    chk("b2b_rdata", rdata, 32'h0000_0055);

    // Both strobes high: treated as a write.
    op(1'b1, 1'b1, 32'h20, 32'h12345678, 1'b0, 1'b0, 32'd0);
    dbg_addr = 8'd8; #1;
    chk("both_dbg8", dbg_data, 32'h12345678);
    chk("both_rdata", rdata, 32'h0000_0055);

    // Reset in the middle of a write's WAIT phase.
    op(1'b0, 1'b1, 32'h0C, 32'h0000_0001, 1'b0, 1'b0, 32'd0);
    req_write = 1'b1; addr = 32'h0C; wdata = 32'hAAAA5555;
    tick();
    req_write = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_rdata", rdata, 32'd0);
    tick();
    rst = 1'b0;
    tick(); tick();
    dbg_addr = 8'd3; #1;
    chk("midrst_done2", 32'(done), 32'd0);
    chk("midrst_w3", dbg_data, 32'h0000_0001);

    // Misaligned write: faulted with the check, lands in word 4 without it.
    op(1'b0, 1'b1, 32'h12, 32'hCAFE0000, ALN, 1'b0, 32'd0);
    dbg_addr = 8'd4; #1;
    chk("mis_w4", dbg_data, ALN ? 32'hDEADBEEF : 32'hCAFE0000);

    // Out-of-range read: wraps to word 8 without the check, faults to 0 with it.
    op(1'b1, 1'b0, 32'h420, 32'd0, ALN, 1'b1, ALN ? 32'd0 : 32'h12345678);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
